// File: rtl/extend_kmers_stream.sv
// Expands each batch of k-mer start indices into flanked base fragments; `EXTENDER_REVCOMP_EN adds rc_mode (reverse complement).
// Latency: the first fragment is registered one edge after accept, then one fragment per handshake without bubbles.
// Backpressure: out_ready low holds every output stable; in_ready is low for the whole batch.
package proj_pkg;
   localparam int BASE_LEN                      = 4;
   localparam int EXTENDER_KMER_LEN             = 4;
   localparam int EXTENDER_FRAG_LEN             = 8;
   localparam int EXTENDER_MEM_LEN_BASES        = 16;
   localparam int EXTENDER_MEM_LEN              = 64;
   localparam int HASHER_EXTENDER_INDICES_COUNT = 2;
   localparam int HASHER_EXTENDER_INDICE_LEN    = 5;
endpackage

module extend_kmers_stream #(
   parameter int KMER_LEN      = proj_pkg::EXTENDER_KMER_LEN,
   parameter int FRAG_LEN      = proj_pkg::EXTENDER_FRAG_LEN,
   parameter int LEFT_FLANK    = (FRAG_LEN - KMER_LEN) / 2,
   parameter int BASE_LEN      = proj_pkg::BASE_LEN,
   parameter int ACTUAL_MEM    = proj_pkg::EXTENDER_MEM_LEN_BASES,
   parameter int MEM_LEN       = proj_pkg::EXTENDER_MEM_LEN,
   parameter int INDICES_COUNT = proj_pkg::HASHER_EXTENDER_INDICES_COUNT,
   parameter int INDICE_LEN    = proj_pkg::HASHER_EXTENDER_INDICE_LEN,
   localparam int IDX_W        = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1,
   localparam int NCNT_W       = $clog2(FRAG_LEN + 1)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [MEM_LEN-1:0]                  memory,
   input  logic [INDICES_COUNT*INDICE_LEN-1:0] kmer_indices,
`ifdef EXTENDER_REVCOMP_EN
   input  logic                                rc_mode,
`endif
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [FRAG_LEN*BASE_LEN-1:0]        out_frag,
   output logic [IDX_W-1:0]                    out_idx,
   output logic                                out_last,
   output logic [NCNT_W-1:0]                   out_n_count
);

   localparam int POS_W = INDICE_LEN + 2;
   // Flank is clamped so the k-mer always fits inside the fragment
   localparam int FLANK = (LEFT_FLANK > FRAG_LEN - KMER_LEN) ? FRAG_LEN - KMER_LEN : LEFT_FLANK;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;

   logic [0:0]                          state_q, state_d;
   logic [MEM_LEN-1:0]                  mem_q, mem_d;
   logic [INDICES_COUNT*INDICE_LEN-1:0] idx_q, idx_d;
   logic [FRAG_LEN*BASE_LEN-1:0]        frag_q, frag_d;
   logic [IDX_W-1:0]                    out_idx_q, out_idx_d;
   logic                                last_q, last_d;
   logic [NCNT_W-1:0]                   ncnt_q, ncnt_d;

   logic                                accept, hs;
   logic [IDX_W-1:0]                    nxt_idx;
   logic [MEM_LEN-1:0]                  sel_mem;
   logic [INDICE_LEN-1:0]               sel_index;
   logic signed [POS_W-1:0]             pos;
   logic [BASE_LEN:0]                   fb;
   logic [FRAG_LEN*BASE_LEN-1:0]        fwd_frag, built_frag;
   logic [NCNT_W-1:0]                   built_ncnt;

   // Returns {in_range, base}; out-of-range positions give N
   function automatic logic [BASE_LEN:0] fetch_base(input logic [MEM_LEN-1:0] mem,
                                                    input logic signed [POS_W-1:0] p);
      fetch_base = '0;
      for (int b = 0; b < ACTUAL_MEM; b++) begin
         if (p == $signed(POS_W'(b))) fetch_base = {1'b1, mem[b*BASE_LEN +: BASE_LEN]};
      end
   endfunction

   assign in_ready = (state_q == IDLE);
   assign out_valid = (state_q == EMIT);
   assign accept = in_ready && in_valid;
   assign hs = out_valid && out_ready;
   assign nxt_idx = out_idx_q + IDX_W'(1);

   // First fragment is built straight from the ports so it lands one edge after accept
   always_comb begin
      sel_mem = mem_q;
      sel_index = '0;
      if (state_q == IDLE) begin
         sel_mem = memory;
         sel_index = kmer_indices[INDICE_LEN-1:0];
      end else begin
         for (int i = 0; i < INDICES_COUNT; i++) begin
            if (nxt_idx == IDX_W'(i)) sel_index = idx_q[i*INDICE_LEN +: INDICE_LEN];
         end
      end
   end

   always_comb begin
      fwd_frag = '0;
      built_ncnt = '0;
      pos = '0;
      fb = '0;
      for (int j = 0; j < FRAG_LEN; j++) begin
         pos = $signed({2'b00, sel_index}) - $signed(POS_W'(FLANK)) + $signed(POS_W'(j));
         fb = fetch_base(sel_mem, pos);
         fwd_frag[j*BASE_LEN +: BASE_LEN] = fb[BASE_LEN-1:0];
         if (!fb[BASE_LEN]) built_ncnt = built_ncnt + NCNT_W'(1);
      end
   end

`ifdef EXTENDER_REVCOMP_EN
   logic rc_q, rc_d;
   logic sel_rc;

   assign sel_rc = (state_q == IDLE) ? rc_mode : rc_q;

   // Complement is the bit-reversed code, so reversal of bases and bits folds into one index flip
   always_comb begin
      built_frag = fwd_frag;
      if (sel_rc) begin
         for (int j = 0; j < FRAG_LEN; j++) begin
            for (int k = 0; k < BASE_LEN; k++) begin
               built_frag[j*BASE_LEN + k] = fwd_frag[(FRAG_LEN-1-j)*BASE_LEN + (BASE_LEN-1-k)];
            end
         end
      end
   end

   always_comb begin
      rc_d = rc_q;
      if (accept) rc_d = rc_mode;
   end

   always_ff @(posedge clk) begin
      if (rst) rc_q <= 1'b0;
      else     rc_q <= rc_d;
   end
`else
   assign built_frag = fwd_frag;
`endif

   always_comb begin
      state_d = state_q;
      mem_d = mem_q;
      idx_d = idx_q;
      frag_d = frag_q;
      out_idx_d = out_idx_q;
      last_d = last_q;
      ncnt_d = ncnt_q;
      if (accept) begin
         state_d = EMIT;
         mem_d = memory;
         idx_d = kmer_indices;
         frag_d = built_frag;
         out_idx_d = '0;
         last_d = (INDICES_COUNT == 1);
         ncnt_d = built_ncnt;
      end else if (hs) begin
         if (last_q) begin
            state_d = IDLE;
            last_d = 1'b0;
         end else begin
            frag_d = built_frag;
            out_idx_d = nxt_idx;
            last_d = (nxt_idx == IDX_W'(INDICES_COUNT - 1));
            ncnt_d = built_ncnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mem_q <= '0;
         idx_q <= '0;
         frag_q <= '0;
         out_idx_q <= '0;
         last_q <= 1'b0;
         ncnt_q <= '0;
      end else begin
         state_q <= state_d;
         mem_q <= mem_d;
         idx_q <= idx_d;
         frag_q <= frag_d;
         out_idx_q <= out_idx_d;
         last_q <= last_d;
         ncnt_q <= ncnt_d;
      end
   end

   assign out_frag = frag_q;
   assign out_idx = out_idx_q;
   assign out_last = last_q;
   assign out_n_count = ncnt_q;

endmodule

// File: tb/tb_extend_kmers_stream.sv
// Bench for extend_kmers_stream: directed scenarios plus randomized batches checked against a base-position model.
module tb_extend_kmers_stream;
   localparam int KL = 4, FL = 8, LF = 2, BL = 4, AM = 16, ML = 64, IC = 2, IL = 5;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, out_last, rc_mode;
   logic [63:0] memory;
   logic [9:0]  kmer_indices;
   logic [31:0] out_frag;
   logic [0:0]  out_idx;
   logic [3:0]  out_n_count;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   extend_kmers_stream #(
      .KMER_LEN(KL), .FRAG_LEN(FL), .LEFT_FLANK(LF), .BASE_LEN(BL), .ACTUAL_MEM(AM),
      .MEM_LEN(ML), .INDICES_COUNT(IC), .INDICE_LEN(IL)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .memory(memory), .kmer_indices(kmer_indices),
`ifdef EXTENDER_REVCOMP_EN
      .rc_mode(rc_mode),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_frag(out_frag),
      .out_idx(out_idx), .out_last(out_last), .out_n_count(out_n_count)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: base j sits at memory position index-LF+j; anything outside [0,AM) is N
   function automatic logic [31:0] model_frag(input logic [63:0] m, input int index, input bit rc);
      logic [3:0] fwd [FL];
      logic [3:0] b;
      int p;
      model_frag = '0;
      for (int j = 0; j < FL; j++) begin
         p = index - LF + j;
         fwd[j] = 4'b0000;
         if (p >= 0 && p < AM) fwd[j] = m[p*4 +: 4];
      end
      for (int j = 0; j < FL; j++) begin
         if (rc) begin
            b = fwd[FL-1-j];
            model_frag[j*4 +: 4] = {b[0], b[1], b[2], b[3]};
         end else begin
            model_frag[j*4 +: 4] = fwd[j];
         end
      end
   endfunction

   function automatic int model_n(input int index);
      int p;
      model_n = 0;
      for (int j = 0; j < FL; j++) begin
         p = index - LF + j;
         if (p < 0 || p >= AM) model_n++;
      end
   endfunction

   function automatic logic [63:0] acgt_mem();
      acgt_mem = '0;
      for (int b = 0; b < AM; b++) acgt_mem[b*4 +: 4] = 4'b0001 << (b % 4);
   endfunction

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rc_mode = 1'b0;
      memory = '0; kmer_indices = '0;
      tick; tick;
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_frag !== 32'h0) begin errors++; $display("FAIL reset_out_frag: got %h want 0", out_frag); end
      checks++; if (out_idx !== 1'b0) begin errors++; $display("FAIL reset_out_idx: got %h want 0", out_idx); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
      checks++; if (out_n_count !== 4'd0) begin errors++; $display("FAIL reset_n_count: got %0d want 0", out_n_count); end
   endtask

   task automatic test_basic_batch;
      logic [63:0] m;
      m = acgt_mem();
      memory = m; kmer_indices = {5'd6, 5'd5}; out_ready = 1'b1; in_valid = 1'b1;
      tick;
      in_valid = 1'b0; memory = ~m; kmer_indices = '1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0: got %b want 1", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_busy: got %b want 0", in_ready); end
      checks++; if (out_idx !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL basic_idx0: got idx=%h last=%b want 0/0", out_idx, out_last); end
      checks++; if (out_frag !== model_frag(m, 5, 1'b0)) begin errors++; $display("FAIL basic_frag0: got %h want %h", out_frag, model_frag(m, 5, 1'b0)); end
      checks++; if (out_n_count !== 4'd0) begin errors++; $display("FAIL basic_n0: got %0d want 0", out_n_count); end
      tick;
      checks++; if (out_valid !== 1'b1 || out_idx !== 1'b1 || out_last !== 1'b1) begin errors++; $display("FAIL basic_idx1: got v=%b idx=%h last=%b want 1/1/1", out_valid, out_idx, out_last); end
      checks++; if (out_frag !== model_frag(m, 6, 1'b0)) begin errors++; $display("FAIL basic_frag1: got %h want %h", out_frag, model_frag(m, 6, 1'b0)); end
      tick;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_done: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_boundary;
      logic [63:0] m;
      m = acgt_mem();
      memory = m; kmer_indices = {5'd14, 5'd0}; out_ready = 1'b1; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      checks++; if (out_frag !== model_frag(m, 0, 1'b0)) begin errors++; $display("FAIL bound_frag_lo: got %h want %h", out_frag, model_frag(m, 0, 1'b0)); end
      checks++; if (out_n_count !== 4'd2) begin errors++; $display("FAIL bound_n_lo: got %0d want 2", out_n_count); end
      tick;
      checks++; if (out_frag !== model_frag(m, 14, 1'b0)) begin errors++; $display("FAIL bound_frag_hi: got %h want %h", out_frag, model_frag(m, 14, 1'b0)); end
      checks++; if (out_n_count !== 4'd4) begin errors++; $display("FAIL bound_n_hi: got %0d want 4", out_n_count); end
      tick;
   endtask

   task automatic test_backpressure;
      logic [63:0] m;
      logic [9:0]  ix;
      logic [31:0] ef;
      m = {$urandom, $urandom}; ix = 10'($urandom);
      memory = m; kmer_indices = ix; out_ready = 1'b0; in_valid = 1'b1; rc_mode = 1'b0;
      tick;
      ef = model_frag(m, int'(ix[4:0]), 1'b0);
      for (int c = 0; c < 5; c++) begin
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL stall_ctrl cycle %0d: got v=%b rdy=%b idx=%h last=%b want 1/0/0/0", c, out_valid, in_ready, out_idx, out_last); end
         checks++; if (out_frag !== ef || out_n_count !== 4'(model_n(int'(ix[4:0])))) begin errors++; $display("FAIL stall_data cycle %0d: got %h/%0d want %h/%0d", c, out_frag, out_n_count, ef, model_n(int'(ix[4:0]))); end
         in_valid = c[0]; memory = {$urandom, $urandom}; kmer_indices = 10'($urandom);
         tick;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick;
      checks++; if (out_idx !== 1'b1 || out_frag !== model_frag(m, int'(ix[9:5]), 1'b0)) begin errors++; $display("FAIL stall_after: got idx=%h %h want 1 %h", out_idx, out_frag, model_frag(m, int'(ix[9:5]), 1'b0)); end
      tick;
   endtask

   task automatic test_reset_abort;
      memory = acgt_mem(); kmer_indices = {5'd9, 5'd3}; out_ready = 1'b1; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_idx !== 1'b0) begin errors++; $display("FAIL abort_idx0: got v=%b idx=%h want 1/0", out_valid, out_idx); end
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_reset: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
      for (int c = 0; c < 4; c++) begin
         tick;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_idx1 cycle %0d: got v=%b want 0", c, out_valid); end
      end
   endtask

`ifdef EXTENDER_REVCOMP_EN
   task automatic test_revcomp;
      logic [31:0] ef;
      ef = '0;
      for (int j = 0; j < FL; j++) ef[j*4 +: 4] = 4'b1000 >> ((10 - j) % 4);
      memory = acgt_mem(); kmer_indices = {5'd5, 5'd5}; out_ready = 1'b1; rc_mode = 1'b1; in_valid = 1'b1;
      tick;
      in_valid = 1'b0; rc_mode = 1'b0;
      checks++; if (out_frag !== ef || out_n_count !== 4'd0) begin errors++; $display("FAIL rc_frag0: got %h/%0d want %h/0", out_frag, out_n_count, ef); end
      tick;
      checks++; if (out_frag !== ef) begin errors++; $display("FAIL rc_frag1: got %h want %h", out_frag, ef); end
      tick;
   endtask
`endif

   task automatic test_random;
      logic [63:0] m;
      logic [9:0]  ix;
      bit          r, done;
      int          ei, xi;
      for (int b = 0; b < 40; b++) begin
         m = {$urandom, $urandom}; ix = 10'($urandom);
`ifdef EXTENDER_REVCOMP_EN
         rc_mode = 1'($urandom_range(0, 1));
`else
         rc_mode = 1'b0;
`endif
         r = rc_mode;
         memory = m; kmer_indices = ix; in_valid = 1'b1;
         tick;
         ei = 0; done = 1'b0;
         for (int c = 0; c < 100 && !done; c++) begin
            xi = int'(ix[ei*IL +: IL]);
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== 1'(ei) || out_last !== (ei == IC - 1)) begin errors++; $display("FAIL rand_ctrl batch %0d: got v=%b rdy=%b idx=%h last=%b want idx %0d", b, out_valid, in_ready, out_idx, out_last, ei); end
            checks++; if (out_frag !== model_frag(m, xi, r) || out_n_count !== 4'(model_n(xi))) begin errors++; $display("FAIL rand_data batch %0d idx %0d: got %h/%0d want %h/%0d", b, ei, out_frag, out_n_count, model_frag(m, xi, r), model_n(xi)); end
            out_ready = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            memory = {$urandom, $urandom}; kmer_indices = 10'($urandom);
            if (out_ready) begin
               if (ei == IC - 1) done = 1'b1;
               else ei++;
            end
            tick;
         end
         checks++; if (!done) begin errors++; $display("FAIL rand_timeout batch %0d: got idx %0d want completion", b, ei); end
         checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rand_idle batch %0d: got v=%b rdy=%b want 0/1", b, out_valid, in_ready); end
      end
      in_valid = 1'b0;
      tick;
   endtask

   initial begin
      test_reset;
      test_basic_batch;
      test_boundary;
      test_backpressure;
      test_reset_abort;
`ifdef EXTENDER_REVCOMP_EN
      test_revcomp;
`endif
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
